// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Imported by the loader FSM and its word packer.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
   localparam int         LEN_WIDTH      = 16;
   localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Emits a registered one-cycle word_valid pulse together with the finished word.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_last,
   output logic        word_valid,
   output logic [31:0] word_data
);

   localparam int LANES_HELD = BYTES_PER_WORD - 1;

   logic [1:0]  byte_idx_reg;
   logic [7:0]  lane_reg [LANES_HELD];
   logic [31:0] word_cat;
   logic        word_valid_reg;
   logic [31:0] word_data_reg;

   assign word_last = (byte_idx_reg == 2'(LANES_HELD));

   // The top lane comes straight from the incoming byte so the word is
   // complete on the same edge that accepts its last byte.
   assign word_cat[31:24] = byte_data;

   genvar gi;
   generate
      for (gi = 0; gi < LANES_HELD; gi++) begin : g_lane
         assign word_cat[8*gi +: 8] = lane_reg[gi];

         always_ff @(posedge clk) begin
            if (reset) begin
               lane_reg[gi] <= '0;
            end else if (byte_valid && byte_idx_reg == 2'(gi)) begin
               lane_reg[gi] <= byte_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx_reg   <= '0;
         word_valid_reg <= 1'b0;
         word_data_reg  <= '0;
      end else begin
         word_valid_reg <= byte_valid && word_last;
         if (clear) begin
            byte_idx_reg <= '0;
         end else if (byte_valid) begin
            byte_idx_reg <= word_last ? 2'd0 : byte_idx_reg + 2'd1;
            if (word_last) begin
               word_data_reg <= word_cat;
            end
         end
      end
   end

   assign word_valid = word_valid_reg;
   assign word_data  = word_data_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a MAGIC/length/payload/checksum frame and writes the
// payload words to instruction memory, releasing the core only on success.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH = 10,
   parameter logic [7:0] MAGIC      = MAGIC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  done,
   output logic                  error
);

   // One extra bit so a full 2**16-word frame still compares cleanly.
   localparam int                   CNT_WIDTH = LEN_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(1) << ADDR_WIDTH;

   state_t                state_reg, state_next;
   logic [LEN_WIDTH-1:0]  len_reg, len_next;
   logic [CNT_WIDTH-1:0]  word_idx_reg, word_idx_next;
   logic [7:0]            chk_reg, chk_next;
   logic [ADDR_WIDTH-1:0] addr_reg;

   logic                  transfer;
   logic                  pack_valid;
   logic                  pack_clear;
   logic                  word_last;
   logic                  word_valid;
   logic [31:0]           word_data;
   logic [CNT_WIDTH-1:0]  n_words;
   logic [CNT_WIDTH-1:0]  word_idx_inc;

   assign in_ready     = !reset && (state_reg != DONE);
   assign transfer     = in_valid && in_ready;
   assign n_words      = {1'b0, in_data, len_reg[7:0]};
   assign word_idx_inc = word_idx_reg + CNT_WIDTH'(1);

   imem_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pack_clear),
      .byte_valid (pack_valid),
      .byte_data  (in_data),
      .word_last  (word_last),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      word_idx_next = word_idx_reg;
      chk_next      = chk_reg;
      pack_valid    = 1'b0;
      pack_clear    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (transfer && in_data == MAGIC) state_next = LEN0;
         end
         LEN0: begin
            if (transfer) begin
               len_next[7:0] = in_data;
               state_next    = LEN1;
            end
         end
         LEN1: begin
            if (transfer) begin
               len_next[15:8] = in_data;
               word_idx_next  = '0;
               chk_next       = '0;
               pack_clear     = 1'b1;
               if (n_words == '0)            state_next = CHK;
               else if (n_words > MAX_WORDS) state_next = ERR;
               else                          state_next = DATA;
            end
         end
         DATA: begin
            if (transfer) begin
               pack_valid = 1'b1;
               chk_next   = chk_reg ^ in_data;
               if (word_last) begin
                  word_idx_next = word_idx_inc;
                  if (word_idx_inc == {1'b0, len_reg}) state_next = CHK;
               end
            end
         end
         CHK: begin
            if (transfer) state_next = (in_data == chk_reg) ? DONE : ERR;
         end
         DONE: begin
            state_next = DONE;
         end
         ERR: begin
            if (transfer && in_data == MAGIC) state_next = LEN0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         len_reg      <= '0;
         word_idx_reg <= '0;
         chk_reg      <= '0;
         addr_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         word_idx_reg <= word_idx_next;
         chk_reg      <= chk_next;
         // Address is captured alongside the packer's word so both land together.
         if (pack_valid && word_last) addr_reg <= word_idx_reg[ADDR_WIDTH-1:0];
      end
   end

   assign imem_we    = word_valid;
   assign imem_addr  = addr_reg;
   assign imem_wdata = word_data;
   assign done       = (state_reg == DONE);
   assign error      = (state_reg == ERR);
   assign core_reset = (state_reg != DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader. It is the writer side of the instruction memory that the core fetches from.
- Accepts a framed byte stream (valid/ready) from a host link such as a UART RX.
- Assembles little-endian 32-bit words and writes them into instruction memory through a word-write port.
- Holds the core in reset until a complete frame with a correct checksum has been loaded.

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_WIDTH.
MAGIC, 8'hA5, frame start byte.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid && in_ready)
imem_we  output  1  one-cycle instruction-memory write strobe
imem_addr  output  ADDR_WIDTH  word address (byte address = imem_addr<<2)
imem_wdata  output  32  instruction word
core_reset  output  1  drives core reset; high until load succeeds
done  output  1  load completed, checksum good
error  output  1  frame rejected (bad length or checksum)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0, state=IDLE, count/checksum/byte index cleared. in_ready=0 while reset is high.
- Frame format: MAGIC, LEN_LO, LEN_HI (N = 16-bit word count), 4*N payload bytes (LSB first per word), CHK. CHK = XOR of all payload bytes; header bytes are excluded.
- in_ready is combinational from state: 1 in IDLE, LEN0, LEN1, DATA, CHK, ERR; 0 in DONE.
- FSM transitions (each taken only on a transfer):
  - IDLE: byte==MAGIC -> LEN0; any other byte is discarded.
  - LEN0: latch LEN_LO -> LEN1.
  - LEN1: latch LEN_HI. N==0 -> CHK. N>MAX_WORDS -> ERR. Otherwise -> DATA with word index 0, byte index 0, checksum 0.
  - DATA: shift the byte into the word buffer at lane byte_idx and XOR it into the checksum.
    - On byte_idx==3: next cycle imem_we=1, imem_addr=word index, imem_wdata=assembled word.
    - Word index increments; byte_idx wraps to 0.
    - After word N-1 -> CHK.
  - CHK: byte==checksum -> DONE; else -> ERR.
  - DONE: done=1 and core_reset=0 from the cycle after the CHK transfer. Terminal until reset.
  - ERR: error=1, core_reset stays 1. A MAGIC byte clears error and -> LEN0; other bytes are dropped.
- imem_we is high for exactly one cycle per word. imem_addr and imem_wdata hold their last values while imem_we=0.
- Write latency: 1 cycle after the transfer of a word's 4th byte.
- Gaps in in_valid (any length, between any bytes) have no effect on results.
- Memory already written before an ERR is not rolled back; the core stays in reset, so it is harmless.
- N==MAX_WORDS is legal; the last write goes to address MAX_WORDS-1 with no wrap.
- Counters: word index is 17 bits internally, compared against N. imem_addr takes its low ADDR_WIDTH bits.
- Reset asserted mid-frame: everything returns to reset values on the next edge. A partial word is never written.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR);
  - MAGIC default;
  - LEN_WIDTH=16;
  - bytes-per-word constant 4.
- Natural sub-module: imem_word_packer (byte lane index, 32-bit shift buffer, word_valid pulse). The FSM, counters and checksum stay in imem_loader.

Test Plan:
1. Frame A5 01 00 93 00 50 00 C3, in_valid held high -> single imem_we pulse with addr 0, wdata 32'h00500093, one cycle after byte 0x00 (the 4th payload byte). done=1 and core_reset=0 the cycle after C3.
2. Garbage 11 22, then a 2-word frame (words 32'h00500093, 32'h00108113), CHK=0xC3^0x13^0x81^0x10^0x00=0x41, random in_valid gaps -> writes at addr 0 and 1 with those words. Garbage ignored; done=1.
3. Same as 1 but CHK=0xC4 -> write to addr 0 occurs. error=1, core_reset stays 1, done=0. A following correct frame clears error, then done=1.
4. A5 00 00 00 -> N=0, CHK 0x00 matches -> no imem_we, done=1.
5. ADDR_WIDTH=2: A5 05 00 -> ERR immediately, no writes. A5 04 00 plus 16 bytes plus correct CHK -> writes to addr 0..3, done=1.
6. Reset for 1 cycle after the 6th payload byte of test 2 -> only addr 0 was written. Outputs return to reset values; a replayed frame completes normally.
